// File: rtl/jogo_sequenciador.sv
// Round sequencer for the game datapath: tick strobes, level/score clears, target LED.
// Build option JOGO_POSICAO_ALEATORIA_EN selects LFSR-driven target positions.
module jogo_sequenciador #(
  parameter int TICK_DIV     = 50000,
  parameter int ROUND_TICKS  = 60000,
  parameter int PAUSE_TICKS  = 500,
  parameter int SCORE_TARGET = 100,
  parameter int NUM_LEDS     = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        pausar,
  input  logic [1:0]  nivel_sel,
  input  logic        ganhou_ponto,
  input  logic        perdeu_ponto,
  input  logic [7:0]  pontuacao,
  output logic        conta_nivel,
  output logic        reset_nivel,
  output logic        reset_ponto,
  output logic [1:0]  nivel_dificuldade,
  output logic [3:0]  position_led,
  output logic [15:0] tempo_restante,
  output logic        jogando,
  output logic        fim_jogo,
  output logic [2:0]  estado
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(PAUSE_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_TICKS);
  localparam logic [15:0]   ROUND_LOAD = 16'(ROUND_TICKS);
  localparam logic [8:0]    SCORE_MAX  = 9'(SCORE_TARGET);
  localparam logic [3:0]    LED_LAST   = 4'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    JOGANDO = 3'd2,
    PONTO   = 3'd3,
    PAUSADO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t        state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [CW-1:0]  pause_q, pause_d;
  logic [15:0]    tempo_q, tempo_d;
  logic [3:0]     pos_q, pos_d;
  logic [1:0]     nivel_q, nivel_d;
  logic           conta_q, conta_d;
  logic           rst_niv_q, rst_niv_d;
  logic           rst_pto_q, rst_pto_d;
  logic           jogando_q, jogando_d;
  logic           fim_q, fim_d;

  logic           active;
  logic           tick;
  logic           over;
  logic [3:0]     seq_next;
  logic [3:0]     adv_pos;

  assign active   = (state_q == JOGANDO) || (state_q == PONTO);
  assign tick     = active && (presc_q == PRESC_LAST);
  assign over     = (tempo_q == '0) || ({1'b0, pontuacao} >= SCORE_MAX);
  assign seq_next = (pos_q == LED_LAST) ? 4'd0 : pos_q + 4'd1;

`ifdef JOGO_POSICAO_ALEATORIA_EN
  logic [3:0] lfsr_q, lfsr_d;
  logic [3:0] cand;

  // x^4+x^3+1 Fibonacci; nonzero seed keeps it off the lock-up state
  assign lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign cand    = 4'({28'd0, lfsr_q} % NUM_LEDS);
  assign adv_pos = (cand == pos_q) ? seq_next : cand;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 4'b1011;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign adv_pos = seq_next;
`endif

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    pause_d   = pause_q;
    tempo_d   = tempo_q;
    pos_d     = pos_q;
    nivel_d   = nivel_q;
    conta_d   = 1'b0;
    rst_niv_d = 1'b0;
    rst_pto_d = 1'b0;

    if (active) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && (tempo_q != '0)) begin
        tempo_d = tempo_q - 16'd1;
      end
    end

    case (state_q)
      INICIAL: begin
        if (iniciar) begin
          state_d   = PREPARA;
          rst_niv_d = 1'b1;
          rst_pto_d = 1'b1;
        end
      end
      PREPARA: begin
        nivel_d = nivel_sel;
        tempo_d = ROUND_LOAD;
        pos_d   = 4'd0;
        presc_d = '0;
        state_d = JOGANDO;
      end
      JOGANDO: begin
        conta_d = tick;
        if (over) begin
          state_d = FIM;
        end else if (pausar) begin
          state_d = PAUSADO;
        end else if (ganhou_ponto || perdeu_ponto) begin
          state_d   = PONTO;
          rst_niv_d = 1'b1;
          pause_d   = PAUSE_LOAD;
          if (ganhou_ponto) begin
            pos_d = adv_pos;
          end
        end
      end
      PONTO: begin
        if (over) begin
          state_d = FIM;
        end else if (pause_q == '0) begin
          state_d = JOGANDO;
        end else if (tick) begin
          pause_d = pause_q - CW'(1);
        end
      end
      PAUSADO: begin
        if (!pausar) begin
          state_d = JOGANDO;
        end
      end
      FIM: begin
        if (iniciar) begin
          state_d   = PREPARA;
          rst_niv_d = 1'b1;
          rst_pto_d = 1'b1;
        end
      end
      default: begin
        state_d = INICIAL;
      end
    endcase

    jogando_d = state_d inside {JOGANDO, PONTO, PAUSADO};
    fim_d     = (state_d == FIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= INICIAL;
      presc_q   <= '0;
      pause_q   <= '0;
      tempo_q   <= '0;
      pos_q     <= '0;
      nivel_q   <= '0;
      conta_q   <= 1'b0;
      rst_niv_q <= 1'b0;
      rst_pto_q <= 1'b0;
      jogando_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      pause_q   <= pause_d;
      tempo_q   <= tempo_d;
      pos_q     <= pos_d;
      nivel_q   <= nivel_d;
      conta_q   <= conta_d;
      rst_niv_q <= rst_niv_d;
      rst_pto_q <= rst_pto_d;
      jogando_q <= jogando_d;
      fim_q     <= fim_d;
    end
  end

  assign conta_nivel       = conta_q;
  assign reset_nivel       = rst_niv_q;
  assign reset_ponto       = rst_pto_q;
  assign nivel_dificuldade = nivel_q;
  assign position_led      = pos_q;
  assign tempo_restante    = tempo_q;
  assign jogando           = jogando_q;
  assign fim_jogo          = fim_q;
  assign estado            = state_q;

endmodule

// File: doc/jogo_sequenciador.md
Name: jogo_sequenciador

Overview:
- Round-level controller that sequences the game datapath: the level counters, the score counter and the target LED.
- Turns start/pause buttons into registered control strobes for the datapath:
  - conta_nivel ticks
  - reset_nivel / reset_ponto pulses
  - latched nivel_dificuldade
  - target position_led
- Watches ganhou_ponto / perdeu_ponto / pontuacao to run point pauses, round timeout and end-of-game.
- Sits between the input debouncers and the game datapath controller.

Parameters:
- TICK_DIV, 50000, clock cycles per conta_nivel pulse (1 kHz at 50 MHz); must be >= 2.
- ROUND_TICKS, 60000, round length in ticks; must be < 65536.
- PAUSE_TICKS, 500, ticks held in PONTO after each point event; must be >= 1.
- SCORE_TARGET, 100, pontuacao value that ends the game early.
- NUM_LEDS, 10, number of target LEDs; position_led range is 0..NUM_LEDS-1.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  debounced one-cycle start pulse.
- pausar  in  1  level; high requests pause.
- nivel_sel  in  2  requested difficulty; sampled only in PREPARA.
- ganhou_ponto  in  1  from datapath.
- perdeu_ponto  in  1  from datapath.
- pontuacao  in  8  current score from datapath.
- conta_nivel  out  1  one-cycle tick strobe.
- reset_nivel  out  1  one-cycle sync clear of the level counters.
- reset_ponto  out  1  one-cycle sync clear of the score.
- nivel_dificuldade  out  2  latched level.
- position_led  out  4  current target LED.
- tempo_restante  out  16  remaining round ticks.
- jogando  out  1  high in JOGANDO, PONTO and PAUSADO.
- fim_jogo  out  1  high in FIM.
- estado  out  3  state code, for debug and display.

Behaviour:
- General:
  - All outputs registered.
  - On reset low, asynchronously: every output 0, estado=INICIAL, prescaler and pause counter 0.
- State encoding: INICIAL=0, PREPARA=1, JOGANDO=2, PONTO=3, PAUSADO=4, FIM=5. Codes 6 and 7 return to INICIAL on the next cycle.
- INICIAL: idle, all strobes 0. iniciar -> PREPARA.
- PREPARA (exactly 1 cycle):
  - reset_nivel=1 and reset_ponto=1 for that cycle.
  - Latch nivel_dificuldade<=nivel_sel; load tempo_restante<=ROUND_TICKS; position_led<=0; prescaler<=0.
  - -> JOGANDO.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1 in JOGANDO and PONTO, and wraps.
  - A wrap produces a tick: conta_nivel=1 for one cycle, in JOGANDO only.
  - Every tick in JOGANDO or PONTO decrements tempo_restante, saturating at 0.
  - In PAUSADO the prescaler and timer are frozen.
- JOGANDO transitions, evaluated in priority order each cycle:
  1. tempo_restante==0 or pontuacao>=SCORE_TARGET -> FIM.
  2. pausar=1 -> PAUSADO.
  3. ganhou_ponto=1 -> PONTO, and advance position_led.
  4. perdeu_ponto=1 -> PONTO, position_led unchanged.
  - If ganhou_ponto and perdeu_ponto are both high, ganhou_ponto wins.
- PONTO:
  - reset_nivel=1 on the entry cycle only.
  - Pause counter loaded with PAUSE_TICKS, decremented per tick.
  - Inputs ganhou/perdeu are ignored.
  - When the counter reaches 0 -> JOGANDO.
  - Timeout or score target during PONTO -> FIM, with timeout/score taking priority.
- PAUSADO:
  - All strobes 0.
  - pausar=0 -> resume the state saved on entry (JOGANDO only; pausar is ignored in PONTO).
- FIM:
  - fim_jogo=1; timer and position hold.
  - iniciar -> PREPARA (new game); otherwise stay.
- iniciar while jogando=1 is ignored.
- Reset mid-game: immediate return to INICIAL; no strobes are emitted.
- Position advance (default): position_led <= (position_led==NUM_LEDS-1) ? 0 : position_led+1.

Optional Feature:
- Macro: JOGO_POSICAO_ALEATORIA_EN.
- When defined:
  - A free-running 4-bit LFSR (x^4+x^3+1, seed 4'b1011, never zero) advances every clock.
  - On advance, candidate = lfsr mod NUM_LEDS.
  - If candidate==position_led, use (position_led+1) mod NUM_LEDS instead.
- When undefined: sequential advance as above, and no LFSR logic is present.

Test Plan (TICK_DIV=4, ROUND_TICKS=20, PAUSE_TICKS=2, SCORE_TARGET=3, NUM_LEDS=10, macro off):
- Reset low then release -> all outputs 0, estado=0. Pulse iniciar with nivel_sel=2 -> one cycle with reset_nivel=reset_ponto=1, then nivel_dificuldade=2, tempo_restante=20, estado=2.
- Run 12 clocks in JOGANDO -> exactly 3 conta_nivel pulses, 4 cycles apart; tempo_restante=17.
- Pulse ganhou_ponto -> estado=3, reset_nivel=1 for one cycle, position_led 0->1, no conta_nivel for 2 ticks, then estado=2. From position_led=9, another ganhou_ponto -> 0.
- Assert ganhou_ponto and perdeu_ponto in the same cycle -> treated as ganhou_ponto (position advances). Hold pausar for 10 cycles -> estado=4, tempo_restante frozen; release -> estado=2.
- Drive pontuacao=3 -> estado=5, fim_jogo=1, jogando=0. Separately, let the timer run out -> tempo_restante=0 and FIM. iniciar from FIM -> PREPARA strobes again.
- Assert reset low while in PONTO -> all outputs 0 immediately, asynchronously; no reset_nivel pulse after reset is released.
